// File: rtl/buf_addr_sched.sv
// Packet buffer block scheduler: hands out free block base addresses to the
// ingress writer and queues completed packets for readout in arrival order.
module buf_addr_sched #(
    parameter int NBLK  = 16,
    parameter int BLK_W = 7
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_pkt_req,
    input  logic        in_pkt_done,
    input  logic        out_ready,
    input  logic        rd_done,
    output logic [10:0] addr2data_waddr,
    output logic        addr2data_waddr_wr,
    output logic [10:0] addr2data_raddr,
    output logic        addr2data_raddr_wr,
    output logic        pkt_drop,
    output logic [4:0]  free_cnt,
    output logic [4:0]  q_cnt
);

    localparam int ID_W   = $clog2(NBLK);
    localparam int ADDR_W = 11;

    typedef enum logic {W_IDLE, W_BUSY} w_state_t;
    typedef enum logic {R_IDLE, R_BUSY} r_state_t;

    w_state_t          r_wstate, w_wstate_nxt;
    r_state_t          r_rstate, w_rstate_nxt;

    logic [NBLK-1:0]   r_bitmap;
    logic [NBLK-1:0]   w_bitmap_nxt;
    logic [ID_W-1:0]   r_wid;
    logic [ID_W-1:0]   r_rid;
    logic [ID_W-1:0]   r_fifo [NBLK];
    logic [ID_W-1:0]   r_wptr;
    logic [ID_W-1:0]   r_rptr;
    logic [4:0]        r_free_cnt;
    logic [4:0]        r_q_cnt;
    logic [ADDR_W-1:0] r_waddr;
    logic [ADDR_W-1:0] r_raddr;
    logic              r_waddr_wr;
    logic              r_raddr_wr;
    logic              r_pkt_drop;

    logic [ID_W-1:0]   w_alloc_id;
    logic [ID_W-1:0]   w_head_id;
    logic              w_found;
    logic              w_alloc;
    logic              w_drop;
    logic              w_push;
    logic              w_pop;
    logic              w_free;

    // Lowest-index free block wins
    always_comb begin
        w_alloc_id = '0;
        w_found    = 1'b0;
        for (int unsigned i = 0; i < NBLK; i++) begin
            if (r_bitmap[i] && !w_found) begin
                w_alloc_id = ID_W'(i);
                w_found    = 1'b1;
            end
        end
    end

    assign w_head_id = r_fifo[r_rptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wstate <= W_IDLE;
            r_rstate <= R_IDLE;
        end else begin
            r_wstate <= w_wstate_nxt;
            r_rstate <= w_rstate_nxt;
        end
    end

    always_comb begin
        w_wstate_nxt = r_wstate;
        w_alloc      = 1'b0;
        w_drop       = 1'b0;
        w_push       = 1'b0;
        case (r_wstate)
            W_IDLE: begin
                if (in_pkt_req) begin
                    if (r_free_cnt != '0) begin
                        w_alloc      = 1'b1;
                        w_wstate_nxt = W_BUSY;
                    end else begin
                        w_drop = 1'b1;
                    end
                end
            end
            W_BUSY: begin
                w_drop = in_pkt_req;
                if (in_pkt_done) begin
                    w_push       = 1'b1;
                    w_wstate_nxt = W_IDLE;
                end
            end
            default: w_wstate_nxt = W_IDLE;
        endcase
    end

    // Pop only sees the registered count, so a same-cycle push is never popped
    always_comb begin
        w_rstate_nxt = r_rstate;
        w_pop        = 1'b0;
        w_free       = 1'b0;
        case (r_rstate)
            R_IDLE: begin
                if (r_q_cnt != '0 && out_ready) begin
                    w_pop        = 1'b1;
                    w_rstate_nxt = R_BUSY;
                end
            end
            R_BUSY: begin
                if (rd_done) begin
                    w_free       = 1'b1;
                    w_rstate_nxt = R_IDLE;
                end
            end
            default: w_rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        w_bitmap_nxt = r_bitmap;
        if (w_alloc) w_bitmap_nxt[w_alloc_id] = 1'b0;
        if (w_free)  w_bitmap_nxt[r_rid]      = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_bitmap   <= '1;
            r_free_cnt <= 5'(NBLK);
            r_q_cnt    <= '0;
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_wid      <= '0;
            r_rid      <= '0;
            r_waddr    <= '0;
            r_raddr    <= '0;
            r_waddr_wr <= 1'b0;
            r_raddr_wr <= 1'b0;
            r_pkt_drop <= 1'b0;
        end else begin
            r_bitmap   <= w_bitmap_nxt;
            r_free_cnt <= r_free_cnt + 5'(w_free) - 5'(w_alloc);
            r_q_cnt    <= r_q_cnt + 5'(w_push) - 5'(w_pop);
            r_waddr_wr <= w_alloc;
            r_raddr_wr <= w_pop;
            r_pkt_drop <= w_drop;
            if (w_alloc) begin
                r_wid   <= w_alloc_id;
                r_waddr <= ADDR_W'(w_alloc_id) << BLK_W;
            end
            if (w_push) r_wptr <= r_wptr + ID_W'(1);
            if (w_pop) begin
                r_rid   <= w_head_id;
                r_raddr <= ADDR_W'(w_head_id) << BLK_W;
                r_rptr  <= r_rptr + ID_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_fifo[r_wptr] <= r_wid;
    end

    assign addr2data_waddr    = r_waddr;
    assign addr2data_waddr_wr = r_waddr_wr;
    assign addr2data_raddr    = r_raddr;
    assign addr2data_raddr_wr = r_raddr_wr;
    assign pkt_drop           = r_pkt_drop;
    assign free_cnt           = r_free_cnt;
    assign q_cnt              = r_q_cnt;

endmodule
